// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: issues one read-address/read-data transaction per fetch request.
// Latency: 3 cycles from request to inst_valid with immediate arready and rvalid.
// Backpressure: arvalid holds until arready; rready holds in DATA/DROP until rvalid; pipe_stall only blocks new issue.
module instruction_fetch_controller #(
  parameter int                   DATA_SIZE = 32,
  parameter int                   ADDR_SIZE = 32,
  parameter logic [DATA_SIZE-1:0] NOP_INST  = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] pc,
  input  logic                 fetch_req,
  input  logic                 flush,
  input  logic                 pipe_stall,
  output logic [ADDR_SIZE-1:0] araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [DATA_SIZE-1:0] rdata,
  input  logic                 rvalid,
  output logic                 rready,
  output logic [DATA_SIZE-1:0] instruction,
  output logic [DATA_SIZE-1:0] past_instruction,
  output logic                 bus_stall,
  output logic                 inst_valid
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;

  state_t state, state_next;
  logic   flush_pending;
  logic   issue;   // start a new transaction this cycle
  logic   accept;  // returned data is taken as the new instruction

  assign bus_stall = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    arvalid    = 1'b0;
    rready     = 1'b0;
    issue      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req && !pipe_stall && !flush) begin
          issue      = 1'b1;
          state_next = ADDR;
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = (flush || flush_pending) ? DROP : DATA;
      end
      DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          // A flush in the same cycle as the data kills it.
          accept     = !flush;
          state_next = IDLE;
        end else if (flush) begin
          state_next = DROP;
        end
      end
      DROP: begin
        rready = 1'b1;
        if (rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Remember a flush seen while the address is still waiting for arready
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       flush_pending <= 1'b0;
    else if (state_next == IDLE)                   flush_pending <= 1'b0;
    else if (state == ADDR && flush && !arready)   flush_pending <= 1'b1;
  end

  // Capture the fetch address at issue; it stays stable through the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        araddr <= '0;
    else if (issue) araddr <= pc;
  end

  // Accepted instruction and its one-cycle valid pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_INST;
      inst_valid  <= 1'b0;
    end else begin
      inst_valid <= accept;
      if (accept) instruction <= rdata;
    end
  end

  // Decode-stage copy advances only when neither the pipe nor the bus is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          past_instruction <= NOP_INST;
    else if (!pipe_stall && !bus_stall) past_instruction <= instruction;
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Randomized bench for instruction_fetch_controller with a transaction-level reference model.
// Expected instructions are queued at the completing edge and consumed by an independent monitor.
// Bus responses (arready/rvalid) are randomized to exercise both handshake stalls.
module tb_instruction_fetch_controller;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_req, flush, pipe_stall;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] instruction, past_instruction;
  logic        bus_stall, inst_valid;

  instruction_fetch_controller #(.DATA_SIZE(32), .ADDR_SIZE(32), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .flush(flush),
    .pipe_stall(pipe_stall), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .instruction(instruction),
    .past_instruction(past_instruction), .bus_stall(bus_stall), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one transaction in flight, tracked as "outstanding",
  // "address accepted" and "killed by a flush at any point of its life".
  bit          m_busy, m_adone, m_killed;
  logic [31:0] m_addr, m_inst, m_past;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_adone = 0; m_killed = 0;
    m_addr = '0; m_inst = NOP; m_past = NOP;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    chk("arvalid", {31'b0, arvalid}, {31'b0, m_busy && !m_adone});
    chk("rready", {31'b0, rready}, {31'b0, m_busy && m_adone});
    chk("bus_stall", {31'b0, bus_stall}, {31'b0, m_busy});
    if (m_busy) chk("araddr", araddr, m_addr);
    chk("instruction", instruction, m_inst);
    chk("past_instruction", past_instruction, m_past);
  endtask

  // Called at a falling edge: check current outputs, drive inputs for the next
  // rising edge, advance the model across that edge, then wait a cycle.
  task automatic step(input bit fr, input logic [31:0] p, input bit fl, input bit ps,
                      input bit ar, input bit rv, input logic [31:0] rd);
    check_outputs();
    fetch_req = fr; pc = p; flush = fl; pipe_stall = ps;
    arready = ar; rvalid = rv; rdata = rd;
    if (!ps && !m_busy) m_past = m_inst;
    if (!m_busy) begin
      if (fr && !ps && !fl) begin
        m_busy = 1; m_adone = 0; m_killed = 0; m_addr = p;
      end
    end else if (!m_adone) begin
      if (fl) m_killed = 1;
      if (ar) m_adone = 1;
    end else begin
      if (fl) m_killed = 1;
      if (rv) begin
        m_busy = 0;
        if (!m_killed) begin
          m_inst = rd;
          exp_q.push_back(rd);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 0, 0, 32'h0);
  endtask

  // Monitor: every instruction pulse must match the oldest queued expectation,
  // and every queued expectation must produce a pulse on the following edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (inst_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL inst_valid_spurious: got 1 expected 0 at %0t", $time);
          end else begin
            chk("inst_valid_data", instruction, exp_q.pop_front());
          end
        end else if (exp_q.size() != 0) begin
          checks++; errors++;
          $display("FAIL inst_valid_missing: got 0 expected 1 (data %h) at %0t", exp_q[0], $time);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1; pc = 0; fetch_req = 0; flush = 0; pipe_stall = 0;
    arready = 0; rvalid = 0; rdata = 0;
    model_reset();
    #1;
    check_outputs();
    chk("reset_inst_valid", {31'b0, inst_valid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Basic fetch with immediate handshakes
    step(1, 32'h100, 0, 0, 1, 0, 32'h0);
    step(0, 32'h104, 0, 0, 1, 0, 32'h0);
    step(0, 32'h104, 0, 0, 0, 1, 32'h00A00093);
    idle(2);
    chk("basic_instruction", instruction, 32'h00A00093);

    // Address channel held off for 4 cycles while pc moves
    step(1, 32'h100, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) step(1, 32'h200 + 32'(4 * i), 0, 0, 0, 0, 32'h0);
    step(0, 32'h300, 0, 0, 1, 0, 32'h0);
    step(0, 32'h300, 0, 0, 0, 1, 32'h11111111);
    idle(1);

    // Flush before address handshake: response must be dropped
    step(1, 32'h400, 0, 0, 0, 0, 32'h0);
    step(0, 32'h400, 1, 0, 0, 0, 32'h0);
    step(0, 32'h400, 0, 0, 1, 0, 32'h0);
    step(0, 32'h400, 0, 0, 0, 0, 32'h0);
    step(0, 32'h400, 0, 0, 0, 1, 32'hDEADBEEF);
    idle(2);
    chk("flush_addr_keeps_inst", instruction, 32'h11111111);

    // Flush coincident with rvalid
    step(1, 32'h500, 0, 0, 1, 0, 32'h0);
    step(0, 32'h500, 0, 0, 1, 0, 32'h0);
    step(0, 32'h500, 1, 0, 0, 1, 32'hBADC0DE5);
    idle(2);

    // Pipe stall blocks issue and freezes past_instruction, then release
    for (int i = 0; i < 3; i++) step(1, 32'h600, 0, 1, 1, 1, 32'h0);
    step(1, 32'h600, 0, 0, 1, 0, 32'h0);
    step(0, 32'h600, 0, 1, 1, 0, 32'h0);
    step(0, 32'h600, 0, 1, 0, 1, 32'h22222222);
    idle(2);

    // Reset while waiting for data, then a stray response must be ignored
    step(1, 32'h700, 0, 0, 1, 0, 32'h0);
    step(0, 32'h700, 0, 0, 1, 0, 32'h0);
    check_outputs();
    rst = 1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    @(negedge clk);
    rst = 0;
    step(0, 32'h0, 0, 0, 0, 1, 32'h33333333);
    step(0, 32'h0, 0, 0, 1, 1, 32'h44444444);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, $urandom);
    end
    idle(3);
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 Parameter DATA_SIZE, default 32: instruction and read-data width.
REQ-002 Parameter ADDR_SIZE, default 32: fetch address width.
REQ-003 Parameter NOP_INST, default 32'h00000013: instruction value after reset and on discard.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pc  input  ADDR_SIZE  fetch address from PC stage.
REQ-007 fetch_req  input  1  PC stage requests an instruction at pc.
REQ-008 flush  input  1  branch/jump taken; in-flight fetch result is discarded.
REQ-009 pipe_stall  input  1  downstream hazard stall (instruction_stall).
REQ-010 araddr  output  ADDR_SIZE  read-address channel address.
REQ-011 arvalid  output  1  read-address valid.
REQ-012 arready  input  1  read-address ready from memory.
REQ-013 rdata  input  DATA_SIZE  read data.
REQ-014 rvalid  input  1  read-data valid.
REQ-015 rready  output  1  read-data ready.
REQ-016 instruction  output  DATA_SIZE  most recently accepted instruction.
REQ-017 past_instruction  output  DATA_SIZE  instruction held in decode during stall.
REQ-018 bus_stall  output  1  fetch in progress; pipeline must hold.
REQ-019 inst_valid  output  1  one-cycle pulse: instruction updated this cycle.

Function
REQ-020 FSM states SHALL be IDLE, ADDR, DATA, DROP; one transaction outstanding max.
REQ-021 IDLE: fetch_req=1 and pipe_stall=0 and flush=0 -> ADDR next cycle, araddr latched from pc; otherwise stay.
REQ-022 ADDR: arvalid=1; araddr stable until arvalid&&arready; arvalid never deasserted before handshake.
REQ-023 ADDR handshake: -> DATA, or -> DROP if flush seen this cycle or flush_pending set.
REQ-024 flush in ADDR before handshake SHALL set flush_pending; cleared on entering IDLE.
REQ-025 DATA: rready=1; rvalid=1 and flush=0 -> instruction<=rdata, inst_valid=1 next cycle, -> IDLE.
REQ-026 DATA: flush=1 without rvalid -> DROP; flush=1 with rvalid same cycle -> rdata discarded, -> IDLE, inst_valid=0.
REQ-027 DROP: rready=1; on rvalid discard rdata, -> IDLE; instruction unchanged.
REQ-028 rvalid in IDLE or ADDR SHALL be ignored; rready=0 there.
REQ-029 bus_stall SHALL be 1 combinationally whenever state != IDLE, 0 in IDLE.
REQ-030 past_instruction<=instruction on every edge where pipe_stall=0 and bus_stall=0; else holds.
REQ-031 pipe_stall SHALL NOT abort an issued transaction; it only blocks new issue in IDLE.
REQ-032 Fetch latency: min 3 cycles request-to-inst_valid (IDLE->ADDR->DATA->IDLE) with arready, rvalid immediate.

Reset
REQ-033 rst=1 asynchronously: state IDLE, flush_pending 0, arvalid 0, rready 0, araddr 0, instruction NOP_INST, past_instruction NOP_INST, inst_valid 0; bus_stall 0.
REQ-034 rst mid-transaction SHALL abandon it; no response after reset release is accepted until a new issue.

Verification
REQ-035 pc=0x100, fetch_req=1, arready=1, rvalid with rdata=0x00A00093 next -> araddr=0x100, instruction=0x00A00093, inst_valid pulse once, bus_stall 1 for exactly 2 cycles.
REQ-036 arready held 0 for 4 cycles, pc changes meanwhile -> arvalid stays 1, araddr stays 0x100, bus_stall stays 1.
REQ-037 flush in ADDR before arready -> handshake completes, state DROP, returned 0xDEADBEEF discarded, instruction unchanged, inst_valid never 1.
REQ-038 flush coincident with rvalid in DATA -> rdata discarded, IDLE next, instruction unchanged.
REQ-039 pipe_stall=1 in IDLE with fetch_req=1 -> no arvalid; past_instruction frozen; release -> issue next cycle.
REQ-040 rst asserted in DATA -> immediate IDLE, instruction=past_instruction=0x00000013, arvalid=rready=0.
